// File: rtl/floppy_pkg.sv
// Shared floppy drive definitions: track geometry, recal limit, seek FSM states.
package floppy_pkg;

    localparam int unsigned TRACK_W     = 7;
    localparam int unsigned TIMER_W     = 32;
    localparam int unsigned MAX_TRACK   = 79;
    localparam int unsigned RECAL_LIMIT = 85;

    typedef enum logic [2:0] {
        IDLE,
        DIR_SETUP,
        STEP_HI,
        STEP_LO,
        SETTLE,
        FINISH
    } seek_state_e;

endpackage

// File: rtl/seek_sched_if.sv
// Command/status channel between a seek requester and seek_sched.
interface seek_sched_if;
    import floppy_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_recal;
    logic [TRACK_W-1:0] cmd_track;
    logic               busy;
    logic               done;
    logic               err;
    logic [TRACK_W-1:0] cur_track;
    logic               cal_valid;

    modport master (
        output cmd_valid, cmd_recal, cmd_track,
        input  cmd_ready, busy, done, err, cur_track, cal_valid
    );

    modport slave (
        input  cmd_valid, cmd_recal, cmd_track,
        output cmd_ready, busy, done, err, cur_track, cal_valid
    );

endinterface

// File: rtl/step_timer.sv
// Loadable down-counter; expire_c is high in the last cycle of a loaded interval.
module step_timer
    import floppy_pkg::*;
#(
    parameter int unsigned W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] load_val,
    output logic         expire_c
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load on start, otherwise count down to zero and stop.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c = (cnt_q == W'(1));

endmodule

// File: rtl/seek_sched.sv
// Floppy head seek scheduler: step/dir pulse generation, recalibration, track tracking.
// Optional macro SEEK_TR0_CHECK_EN: cross-check tr0 against cur_track after seek settle.
module seek_sched
    import floppy_pkg::*;
#(
    parameter int unsigned STEP_CYC      = 144000,
    parameter int unsigned PULSE_CYC     = 96,
    parameter int unsigned DIR_SETUP_CYC = 48,
    parameter int unsigned SETTLE_CYC    = 720000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tr0,
    input  logic           dsk_present,
    output logic           step_out,
    output logic           dir_out,
    seek_sched_if.slave    cmd
);

    seek_state_e        state_q, state_d;
    logic               step_q, step_d;
    logic               dir_q, dir_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               cal_q, cal_d;
    logic               recal_q, recal_d;
    logic               err_pend_q, err_pend_d;
    logic [TRACK_W-1:0] cur_q, cur_d;
    logic [TRACK_W-1:0] target_q, target_d;
    logic [TRACK_W-1:0] pulse_cnt_q, pulse_cnt_d;
`ifdef SEEK_TR0_CHECK_EN
    logic               from_zero_q, from_zero_d;
`endif

    logic               tmr_start;
    logic [TIMER_W-1:0] tmr_load;
    logic               tmr_exp;
    logic               accept;

    step_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst),
        .start    (tmr_start),
        .load_val (tmr_load),
        .expire_c (tmr_exp)
    );

    assign accept = cmd.cmd_valid && ready_q;

    // Next-state, track bookkeeping and registered-output decode.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        cal_d       = cal_q;
        recal_d     = recal_q;
        err_pend_d  = err_pend_q;
        cur_d       = cur_q;
        target_d    = target_q;
        pulse_cnt_d = pulse_cnt_q;
`ifdef SEEK_TR0_CHECK_EN
        from_zero_d = from_zero_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    recal_d     = cmd.cmd_recal;
                    target_d    = cmd.cmd_track;
                    err_pend_d  = 1'b0;
                    pulse_cnt_d = '0;
`ifdef SEEK_TR0_CHECK_EN
                    from_zero_d = (cur_q == '0);
`endif
                    if (cmd.cmd_recal) begin
                        dir_d   = 1'b0;
                        cal_d   = 1'b0;
                        state_d = DIR_SETUP;
                    end else if (!cal_q || (cmd.cmd_track > TRACK_W'(MAX_TRACK)) || !dsk_present) begin
                        err_pend_d = 1'b1;
                        state_d    = FINISH;
                    end else if (cmd.cmd_track == cur_q) begin
                        state_d = FINISH;
                    end else begin
                        dir_d   = (cmd.cmd_track > cur_q);
                        state_d = DIR_SETUP;
                    end
                end
            end

            DIR_SETUP: begin
                if (tmr_exp) begin
                    if (!dsk_present) begin
                        err_pend_d = 1'b1;
                        state_d    = FINISH;
                    end else if (recal_q && tr0) begin
                        cur_d   = '0;
                        cal_d   = 1'b1;
                        state_d = SETTLE;
                    end else begin
                        state_d = STEP_HI;
                    end
                end
            end

            // Falling edge of the pulse: the head has moved one track.
            STEP_HI: begin
                if (tmr_exp) begin
                    pulse_cnt_d = pulse_cnt_q + TRACK_W'(1);
                    if (!recal_q) begin
                        cur_d = dir_q ? (cur_q + TRACK_W'(1)) : (cur_q - TRACK_W'(1));
                    end
                    if (!dsk_present) begin
                        err_pend_d = 1'b1;
                        state_d    = FINISH;
                    end else begin
                        state_d = STEP_LO;
                    end
                end
            end

            STEP_LO: begin
                if (tmr_exp) begin
                    if (!dsk_present) begin
                        err_pend_d = 1'b1;
                        state_d    = FINISH;
                    end else if (recal_q) begin
                        if (tr0) begin
                            cur_d   = '0;
                            cal_d   = 1'b1;
                            state_d = SETTLE;
                        end else if (pulse_cnt_q == TRACK_W'(RECAL_LIMIT)) begin
                            cal_d      = 1'b0;
                            err_pend_d = 1'b1;
                            state_d    = SETTLE;
                        end else begin
                            state_d = STEP_HI;
                        end
                    end else if (cur_q == target_q) begin
                        state_d = SETTLE;
                    end else begin
                        state_d = STEP_HI;
                    end
                end
            end

            SETTLE: begin
                if (tmr_exp) begin
                    state_d = FINISH;
`ifdef SEEK_TR0_CHECK_EN
                    if (!recal_q) begin
                        if ((target_q == '0) && !tr0) begin
                            err_pend_d = 1'b1;
                            cal_d      = 1'b0;
                        end else if ((target_q != '0) && from_zero_q && tr0) begin
                            err_pend_d = 1'b1;
                            cal_d      = 1'b0;
                        end
                    end
`endif
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Every timed state is entered by a state change, so the change itself reloads the timer.
        tmr_start = (state_d != state_q);
        case (state_d)
            DIR_SETUP: tmr_load = TIMER_W'(DIR_SETUP_CYC);
            STEP_HI:   tmr_load = TIMER_W'(PULSE_CYC);
            STEP_LO:   tmr_load = TIMER_W'(STEP_CYC - PULSE_CYC);
            SETTLE:    tmr_load = TIMER_W'(SETTLE_CYC);
            default:   tmr_load = '0;
        endcase

        step_d  = (state_d == STEP_HI);
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
        done_d  = (state_d == FINISH);
        err_d   = (state_d == FINISH) && err_pend_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            cal_q       <= 1'b0;
            recal_q     <= 1'b0;
            err_pend_q  <= 1'b0;
            cur_q       <= '0;
            target_q    <= '0;
            pulse_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            cal_q       <= cal_d;
            recal_q     <= recal_d;
            err_pend_q  <= err_pend_d;
            cur_q       <= cur_d;
            target_q    <= target_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

`ifdef SEEK_TR0_CHECK_EN
    // Start-at-track-0 flag for the tr0 cross-check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            from_zero_q <= 1'b0;
        end else begin
            from_zero_q <= from_zero_d;
        end
    end
`endif

    assign step_out      = step_q;
    assign dir_out       = dir_q;
    assign cmd.cmd_ready = ready_q;
    assign cmd.busy      = busy_q;
    assign cmd.done      = done_q;
    assign cmd.err       = err_q;
    assign cmd.cur_track = cur_q;
    assign cmd.cal_valid = cal_q;

endmodule

// File: tb/tb_seek_sched.sv
// Scoreboard bench for seek_sched with shortened timing parameters.
module tb_seek_sched;

    localparam int STEP   = 10;
    localparam int PW     = 3;
    localparam int DSET   = 2;
    localparam int SETL   = 5;
    localparam int RLIMIT = 85;

    typedef struct {
        int   lat;
        logic err;
        int   cur;
        logic cal;
        int   pulses;
        logic dir;
    } exp_t;

    logic clk;
    logic rst;
    logic tr0;
    logic dsk_present;
    logic step_out;
    logic dir_out;

    seek_sched_if sif();

    seek_sched #(
        .STEP_CYC      (STEP),
        .PULSE_CYC     (PW),
        .DIR_SETUP_CYC (DSET),
        .SETTLE_CYC    (SETL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tr0         (tr0),
        .dsk_present (dsk_present),
        .step_out    (step_out),
        .dir_out     (dir_out),
        .cmd         (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   pulses   = 0;
    int   last_rise = 0;
    int   done_cnt = 0;
    logic prev_step = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int lat, input logic err, input int cur,
                                input logic cal, input int np, input logic dir);
        exp_t e;
        e.lat = lat; e.err = err; e.cur = cur; e.cal = cal; e.pulses = np; e.dir = dir;
        return e;
    endfunction

    // Monitor: pulse timing and scoreboard compare on every done.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            prev_step = 1'b0;
        end else begin
            if (sif.cmd_valid && sif.cmd_ready) begin
                acc_cyc = cyc;
                pulses  = 0;
            end
            if (step_out && !prev_step) begin
                if (pulses > 0) chk("step_period", cyc - last_rise, STEP);
                last_rise = cyc;
                pulses++;
            end
            if (!step_out && prev_step) chk("step_width", cyc - last_rise, PW);
            prev_step = step_out;
            if (sif.err) chk("err_with_done", int'(sif.done), 1);
            if (sif.done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency",   cyc - acc_cyc,       e.lat);
                    chk("err",       int'(sif.err),       int'(e.err));
                    chk("cur_track", int'(sif.cur_track), e.cur);
                    chk("cal_valid", int'(sif.cal_valid), int'(e.cal));
                    chk("pulses",    pulses,              e.pulses);
                    chk("dir_out",   int'(dir_out),       int'(e.dir));
                end
                done_cnt++;
            end
        end
    end

    task automatic issue(input logic recal, input int trk, input logic push, input exp_t e);
        int n;
        @(posedge clk);
        #1;
        sif.cmd_valid = 1'b1;
        sif.cmd_recal = recal;
        sif.cmd_track = 7'(trk);
        if (push) q.push_back(e);
        n = 0;
        @(negedge clk);
        while (!sif.cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        sif.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == start) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_pulse(input int np, input logic level);
        int n;
        n = 0;
        while (!(pulses == np && step_out == level) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("pulse_timeout", 0, 1);
    endtask

    initial begin
        exp_t none;
        none = mk(0, 1'b0, 0, 1'b0, 0, 1'b0);
        rst           = 1'b0;
        tr0           = 1'b0;
        dsk_present   = 1'b1;
        sif.cmd_valid = 1'b0;
        sif.cmd_recal = 1'b0;
        sif.cmd_track = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_step",  int'(step_out),      0);
        chk("rst_dir",   int'(dir_out),       0);
        chk("rst_busy",  int'(sif.busy),      0);
        chk("rst_done",  int'(sif.done),      0);
        chk("rst_err",   int'(sif.err),       0);
        chk("rst_cur",   int'(sif.cur_track), 0);
        chk("rst_cal",   int'(sif.cal_valid), 0);
        rst = 1'b1;

        // Uncalibrated seek is rejected immediately.
        issue(1'b0, 5, 1'b1, mk(1, 1'b1, 0, 1'b0, 0, 1'b0));
        wait_done(50);

        // Recal with tr0 rising during the third pulse's low phase.
        issue(1'b1, 0, 1'b1, mk(DSET + 3*STEP + SETL + 1, 1'b0, 0, 1'b1, 3, 1'b0));
        wait_pulse(3, 1'b0);
        tr0 = 1'b1;
        wait_done(200);
        tr0 = 1'b0;

        // Seek 0->4 inward, then 4->1 outward.
        issue(1'b0, 4, 1'b1, mk(DSET + 4*STEP + SETL + 1, 1'b0, 4, 1'b1, 4, 1'b1));
        wait_done(200);
        issue(1'b0, 1, 1'b1, mk(DSET + 3*STEP + SETL + 1, 1'b0, 1, 1'b1, 3, 1'b0));
        wait_done(200);

        // Out-of-range target, then seek to current track.
        issue(1'b0, 80, 1'b1, mk(1, 1'b1, 1, 1'b1, 0, 1'b0));
        wait_done(50);
        issue(1'b0, 1, 1'b1, mk(1, 1'b0, 1, 1'b1, 0, 1'b0));
        wait_done(50);

        // Back to 0, then 0->6 with disk removed during the second pulse.
        issue(1'b0, 0, 1'b1, mk(DSET + STEP + SETL + 1, 1'b0, 0, 1'b1, 1, 1'b0));
        wait_done(200);
        issue(1'b0, 6, 1'b1, mk(DSET + STEP + PW + 1, 1'b1, 2, 1'b1, 2, 1'b1));
        wait_pulse(2, 1'b1);
        dsk_present = 1'b0;
        wait_done(200);
        dsk_present = 1'b1;

        // Recal that never sees tr0.
        issue(1'b1, 0, 1'b1, mk(DSET + RLIMIT*STEP + SETL + 1, 1'b1, 2, 1'b0, RLIMIT, 1'b0));
        wait_done(2000);

        // Reset in the middle of a step pulse.
        issue(1'b1, 0, 1'b0, none);
        wait_pulse(1, 1'b1);
        rst = 1'b0;
        #1;
        chk("midrst_step", int'(step_out),      0);
        chk("midrst_busy", int'(sif.busy),      0);
        chk("midrst_cur",  int'(sif.cur_track), 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", int'(sif.cmd_ready), 1);
        issue(1'b0, 3, 1'b1, mk(1, 1'b1, 0, 1'b0, 0, 1'b0));
        wait_done(50);

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seek_sched.md
SEEK_SCHED -- requirements
Module: seek_sched

Interface
REQ-001 SHALL have parameter STEP_CYC, default 144000, meaning full step period in clk cycles (3 ms at 48 MHz).
REQ-002 SHALL have parameter PULSE_CYC, default 96, meaning step-high width in cycles; PULSE_CYC < STEP_CYC.
REQ-003 SHALL have parameter DIR_SETUP_CYC, default 48, meaning dir-valid-to-first-step delay in cycles.
REQ-004 SHALL have parameter SETTLE_CYC, default 720000, meaning head-settle time after last step (15 ms).
REQ-005 SHALL have these ports: clk input 1 system clock; rst input 1 asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have these ports: cmd_valid input 1 command offered; cmd_ready output 1 command accepted when both high; cmd_recal input 1 recalibrate (ignore cmd_track); cmd_track input 7 target track.
REQ-007 SHALL have these ports: tr0 input 1 head at track 0 (active-high, pre-synchronized); dsk_present input 1 disk inserted.
REQ-008 SHALL have these ports: step_out output 1 step pulse to ctrl_circ step input; dir_out output 1 direction, 1 = inward (increasing track).
REQ-009 SHALL have these ports: busy output 1; done output 1 one-cycle completion pulse; err output 1 one-cycle error pulse, coincident with done; cur_track output 7; cal_valid output 1 cur_track trustworthy.

Function
REQ-010 SHALL implement FSM states IDLE, DIR_SETUP, STEP_HI, STEP_LO, SETTLE, FINISH.
REQ-011 SHALL assert cmd_ready only in IDLE; a command offered while not in IDLE is neither accepted nor queued.
REQ-012 On an accepted seek SHALL reject with done+err next cycle and no steps if cal_valid=0, cmd_track > MAX_TRACK, or dsk_present=0.
REQ-013 On an accepted seek with cmd_track == cur_track SHALL pulse done the next cycle, with no steps and no settle.
REQ-014 Otherwise SHALL drive dir_out, hold DIR_SETUP_CYC, then issue |target-cur| pulses, each PULSE_CYC high then STEP_CYC-PULSE_CYC low.
REQ-015 SHALL update cur_track by ±1 at the falling edge of each step pulse.
REQ-016 After the last pulse SHALL wait SETTLE_CYC, then spend one FINISH cycle with done=1, then return to IDLE.
REQ-017 Recal: dir_out=0; step until tr0=1 is sampled in STEP_LO's final cycle or before the first pulse.
REQ-018 On recal success SHALL set cur_track=0 and cal_valid=1, then settle and finish.
REQ-019 On recal failure (tr0 never seen after RECAL_LIMIT pulses) SHALL set cal_valid=0 and pulse done+err after settle.
REQ-020 If dsk_present falls mid-seek SHALL complete the current pulse, skip settle, pulse done+err, and keep cur_track consistent with pulses issued.
REQ-021 SHALL hold dir_out stable from DIR_SETUP entry until FINISH.
REQ-022 SHALL never assert step_out outside STEP_HI.
REQ-023 SHALL set busy=1 in every state except IDLE.

Reset
REQ-024 While rst=0 SHALL force state=IDLE, step_out=0, dir_out=0, busy=0, done=0, err=0, cur_track=0, cal_valid=0, with counters cleared asynchronously.
REQ-025 Reset asserted mid-pulse SHALL end the pulse immediately; after release SHALL accept a command in the first IDLE cycle.

Configuration
REQ-026 With SEEK_TR0_CHECK_EN defined SHALL, at the end of a seek to track 0, pulse err and clear cal_valid if tr0=0.
REQ-027 With SEEK_TR0_CHECK_EN defined SHALL, on any step away from track 0, pulse err and clear cal_valid if tr0 remains 1 after settle.
REQ-028 Without SEEK_TR0_CHECK_EN SHALL ignore tr0 except during recal.

Structure
REQ-029 SHALL take MAX_TRACK (79), RECAL_LIMIT (85), and the FSM state enum from shared package floppy_pkg.
REQ-030 SHALL implement all cycle delays with one loadable down-counter sub-module, step_timer (load value, start, expire pulse).

Verification
REQ-031 Reset then seek to 5 -> rejected, done+err next cycle, zero step pulses (cal_valid=0).
REQ-032 Recal with tr0 rising after 3 pulses -> exactly 3 pulses, dir_out=0, cur_track=0, cal_valid=1, done after SETTLE_CYC.
REQ-033 With small parameters, seek 0->4 then 4->1 -> 4 pulses with dir_out=1, then 3 pulses with dir_out=0; pulse width and period exact; cur_track=4, then 1.
REQ-034 Seek to 80 -> done+err, no pulses; seek to the current track -> done only, in 1 cycle.
REQ-035 dsk_present dropped during the 2nd pulse of a 0->6 seek -> that pulse completes, done+err, cur_track=2.
REQ-036 Recal with tr0 held 0 -> 85 pulses, err, cal_valid=0; reset mid-pulse -> step_out=0 immediately.
